// File: rtl/elevator_ctrl.sv
// Elevator car controller: serves per-floor requests with a timed travel/door model.
// Optional macro ELEV_SEG_EN adds a registered active-low 7-segment floor display on `seg`.
module elevator_ctrl #(
    parameter int unsigned FLOORS        = 4,
    parameter int unsigned FLOOR_W       = 2,
    parameter int unsigned TRAVEL_CYCLES = 100,
    parameter int unsigned DOOR_CYCLES   = 50
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [FLOORS-1:0]  req,
    output logic [FLOORS-1:0]  fb,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open
`ifdef ELEV_SEG_EN
    ,
    output logic [6:0]         seg
`endif
);

    localparam int unsigned CNT_W       = 16;
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [FLOOR_W-1:0] floor_n;
    logic               dir_n;
    logic [FLOORS-1:0]  fb_n;
    logic               here, above, below;

`ifdef ELEV_SEG_EN
    function automatic logic [6:0] seg_of(input logic [FLOOR_W-1:0] f);
        case (32'(f))
            0:       seg_of = 7'b1111001;
            1:       seg_of = 7'b0100100;
            2:       seg_of = 7'b0110000;
            3:       seg_of = 7'b0011001;
            4:       seg_of = 7'b0010010;
            5:       seg_of = 7'b0000010;
            6:       seg_of = 7'b1111000;
            7:       seg_of = 7'b0000000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction
`endif

    // Request groups relative to the current floor
    always_comb begin
        here  = 1'b0;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < int'(FLOORS); i++) begin
            if (FLOOR_W'(i) == floor) here  = here  | req[i];
            if (FLOOR_W'(i) >  floor) above = above | req[i];
            if (FLOOR_W'(i) <  floor) below = below | req[i];
        end
    end

    // Next-state, counter, position and direction decisions
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        floor_n = floor;
        dir_n   = dir_up;
        fb_n    = '0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (here) begin
                    state_n = DOOR;
                end else if (dir_up) begin
                    if (above) begin
                        state_n = MOVE_UP;
                    end else if (below) begin
                        state_n = MOVE_DOWN;
                        dir_n   = 1'b0;
                    end
                end else begin
                    if (below) begin
                        state_n = MOVE_DOWN;
                    end else if (above) begin
                        state_n = MOVE_UP;
                        dir_n   = 1'b1;
                    end
                end
            end
            MOVE_UP: begin
                if (cnt == TRAVEL_LAST) begin
                    cnt_n   = '0;
                    floor_n = floor + FLOOR_W'(1);
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            MOVE_DOWN: begin
                if (cnt == TRAVEL_LAST) begin
                    cnt_n   = '0;
                    floor_n = floor - FLOOR_W'(1);
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DOOR: begin
                if (cnt == DOOR_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Feedback is registered alongside the state it belongs to
        if (state_n == DOOR) begin
            for (int i = 0; i < int'(FLOORS); i++) begin
                fb_n[i] = (FLOOR_W'(i) == floor_n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= '0;
            floor     <= '0;
            dir_up    <= 1'b1;
            fb        <= '0;
            moving    <= 1'b0;
            door_open <= 1'b0;
`ifdef ELEV_SEG_EN
            seg       <= 7'b1111001;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            floor     <= floor_n;
            dir_up    <= dir_n;
            fb        <= fb_n;
            moving    <= (state_n == MOVE_UP) || (state_n == MOVE_DOWN);
            door_open <= (state_n == DOOR);
`ifdef ELEV_SEG_EN
            seg       <= seg_of(floor_n);
`endif
        end
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed self-checking bench for elevator_ctrl (FLOORS=4, TRAVEL_CYCLES=8, DOOR_CYCLES=6).
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] req;
    logic [3:0] fb;
    logic [1:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
`ifdef ELEV_SEG_EN
    logic [6:0] seg;
`endif

    int tests = 0;
    int fails = 0;

    elevator_ctrl #(
        .FLOORS(4),
        .FLOOR_W(2),
        .TRAVEL_CYCLES(8),
        .DOOR_CYCLES(6)
    ) dut (
        .clk(clk),
        .clr(clr),
        .req(req),
        .fb(fb),
        .floor(floor),
        .dir_up(dir_up),
        .moving(moving),
        .door_open(door_open)
`ifdef ELEV_SEG_EN
        ,
        .seg(seg)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until any feedback line is seen, bounded by max cycles
    task automatic wait_fb(input int max, output logic [3:0] seen, output bit ok);
        seen = '0;
        ok   = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            if (fb != 4'b0000) begin
                seen = fb;
                ok   = 1'b1;
            end
        end
    endtask

    // Count samples with the door open, starting at the current sample
    task automatic wait_door_close(input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            if (door_open) n++;
            else ok = 1'b1;
            if (!ok) tick();
        end
    endtask

    task automatic test_reset();
        bit bad;
        clr = 1'b0;
        req = 4'b0000;
        tick();
        tick();
        clr = 1'b1;
        tests++;
        if (floor !== 2'd0) begin fails++; $display("FAIL reset_floor got %0d want 0", floor); end
        tests++;
        if (fb !== 4'b0000) begin fails++; $display("FAIL reset_fb got %b want 0000", fb); end
        tests++;
        if ({moving, door_open} !== 2'b00) begin
            fails++; $display("FAIL reset_flags got moving=%b door=%b want 0 0", moving, door_open);
        end
        tests++;
        if (dir_up !== 1'b1) begin fails++; $display("FAIL reset_dir got %b want 1", dir_up); end
`ifdef ELEV_SEG_EN
        tests++;
        if (seg !== 7'b1111001) begin fails++; $display("FAIL reset_seg got %b want 1111001", seg); end
`endif
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (moving || door_open || floor != 2'd0 || fb != 4'b0000) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL reset_idle50 got activity want idle"); end
    endtask

    task automatic test_door_here();
        int  n;
        bit  ok;
        req = 4'b0001;
        tick();
        tests++;
        if ({door_open, fb} !== {1'b1, 4'b0001}) begin
            fails++; $display("FAIL here_latency got door=%b fb=%b want 1 0001", door_open, fb);
        end
        req = 4'b0000;
        wait_door_close(20, n, ok);
        tests++;
        if (!ok || n != 6) begin fails++; $display("FAIL here_door_len got %0d ok=%b want 6", n, ok); end
        tests++;
        if ({door_open, fb} !== {1'b0, 4'b0000}) begin
            fails++; $display("FAIL here_clear got door=%b fb=%b want 0 0000", door_open, fb);
        end
    endtask

    task automatic test_travel_up();
        int t1 = -1, t2 = -1, t3 = -1, tf = -1, tm = -1;
        bit dir_bad = 1'b0;
        int n;
        bit ok;
        req = 4'b1000;
        for (int c = 1; c <= 40 && tf < 0; c++) begin
            tick();
            if (!dir_up) dir_bad = 1'b1;
            if (moving && tm < 0) tm = c;
            if (floor == 2'd1 && t1 < 0) t1 = c;
            if (floor == 2'd2 && t2 < 0) t2 = c;
            if (floor == 2'd3 && t3 < 0) t3 = c;
            if (fb[3]) begin
                tf  = c;
                req = 4'b0000;
            end
        end
        tests++;
        if (tm != 1) begin fails++; $display("FAIL up_move_start got %0d want 1", tm); end
        tests++;
        if ({t1, t2, t3} !== {32'd9, 32'd18, 32'd27}) begin
            fails++; $display("FAIL up_floor_times got %0d %0d %0d want 9 18 27", t1, t2, t3);
        end
        tests++;
        if (tf != 28 || fb !== 4'b1000) begin
            fails++; $display("FAIL up_fb got cycle %0d fb=%b want 28 1000", tf, fb);
        end
        wait_door_close(20, n, ok);
        if (!dir_up) dir_bad = 1'b1;
        tests++;
        if (!ok || n != 6) begin fails++; $display("FAIL up_door_len got %0d want 6", n); end
        tests++;
        if (dir_bad) begin fails++; $display("FAIL up_dir got a 0 want 1 throughout"); end
        tests++;
        if (floor !== 2'd3) begin fails++; $display("FAIL up_top_floor got %0d want 3", floor); end
    endtask

    task automatic test_reverse();
        logic [3:0] seen;
        bit         ok;
        int         n;
        clr = 1'b0;
        req = 4'b0000;
        tick();
        clr = 1'b1;
        req = 4'b0010;
        wait_fb(40, seen, ok);
        req = 4'b0000;
        wait_door_close(20, n, ok);
        tests++;
        if ({floor, dir_up} !== {2'd1, 1'b1}) begin
            fails++; $display("FAIL rev_setup got floor=%0d dir=%b want 1 1", floor, dir_up);
        end
        req = 4'b1001;
        wait_fb(60, seen, ok);
        tests++;
        if (!ok || seen !== 4'b1000) begin fails++; $display("FAIL rev_first got fb=%b want 1000", seen); end
        req = 4'b0001;
        wait_door_close(20, n, ok);
        wait_fb(60, seen, ok);
        tests++;
        if (!ok || seen !== 4'b0001 || floor !== 2'd0) begin
            fails++; $display("FAIL rev_second got fb=%b floor=%0d want 0001 0", seen, floor);
        end
        tests++;
        if (dir_up !== 1'b0) begin fails++; $display("FAIL rev_dir got %b want 0", dir_up); end
        req = 4'b0000;
        wait_door_close(20, n, ok);
    endtask

    task automatic test_redoor();
        logic [3:0] seen;
        bit         ok;
        int         n;
        req = 4'b0100;
        wait_fb(60, seen, ok);
        tests++;
        if (!ok || seen !== 4'b0100 || floor !== 2'd2) begin
            fails++; $display("FAIL redoor_arrive got fb=%b floor=%0d want 0100 2", seen, floor);
        end
        req = 4'b0000;
        wait_door_close(20, n, ok);
        req = 4'b0100;
        tick();
        tests++;
        if ({door_open, moving, fb, floor} !== {1'b1, 1'b0, 4'b0100, 2'd2}) begin
            fails++;
            $display("FAIL redoor_again got door=%b moving=%b fb=%b floor=%0d want 1 0 0100 2",
                     door_open, moving, fb, floor);
        end
        req = 4'b0000;
        wait_door_close(20, n, ok);
        tests++;
        if (!ok || n != 6) begin fails++; $display("FAIL redoor_len got %0d want 6", n); end
    endtask

    task automatic test_reset_mid();
        req = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if ({moving, floor, dir_up} !== {1'b1, 2'd2, 1'b0}) begin
            fails++; $display("FAIL mid_setup got moving=%b floor=%0d dir=%b want 1 2 0",
                              moving, floor, dir_up);
        end
        clr = 1'b0;
        tick();
        tests++;
        if ({floor, moving, door_open, fb, dir_up} !== {2'd0, 1'b0, 1'b0, 4'b0000, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset got floor=%0d moving=%b door=%b fb=%b dir=%b want 0 0 0 0000 1",
                     floor, moving, door_open, fb, dir_up);
        end
`ifdef ELEV_SEG_EN
        tests++;
        if (seg !== 7'b1111001) begin fails++; $display("FAIL mid_seg got %b want 1111001", seg); end
`endif
        clr = 1'b1;
        req = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if ({floor, moving, door_open} !== {2'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL mid_after got floor=%0d moving=%b door=%b want 0 0 0",
                              floor, moving, door_open);
        end
    endtask

    initial begin
        clr = 1'b0;
        req = 4'b0000;
        test_reset();
        test_door_here();
        test_travel_up();
        test_reverse();
        test_redoor();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
